// File: rtl/shift_right_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_right_seq_pkg
// Description : Shared types and defaults for the sequential shifters.
//               Holds the three-state FSM encoding and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_right_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_SHW   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Saturate a requested shift amount at the operand width
  function automatic int clamp_amount(input int amt, input int lim);
    return (amt >= lim) ? lim : amt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_right_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_right_seq_if
// Description : Request/result bundle for the sequential right shifter.
//               master drives the request, slave is the shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_right_seq_if
  import shift_right_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = DEFAULT_SHW
);

  logic             start;
  logic [WIDTH-1:0] D;
  logic [SHW-1:0]   B;
  logic             arith;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] R;

  modport master (
    output start, D, B, arith,
    input  busy, done, R
  );

  modport slave (
    input  start, D, B, arith,
    output busy, done, R
  );

endinterface
`default_nettype wire

// File: rtl/shift_right_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_right_seq
// Description : Multi-cycle right shifter, one bit per clock. Logical or
//               arithmetic fill; amounts at or above WIDTH saturate so the
//               result is all fill bits. done pulses one cycle with R valid.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_right_seq
  import shift_right_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = DEFAULT_SHW
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_right_seq_if.slave bus
);

  // Count register must hold the saturated value WIDTH itself
  localparam int CNTW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             fill_q, fill_d;

  logic [SHW-1:0]   w_b_in;
  logic [CNTW-1:0]  w_amt;

  assign w_b_in = bus.B;
  assign w_amt  = CNTW'(clamp_amount(int'(w_b_in), WIDTH));

  // Next-state and datapath update; inputs are only looked at when accepting
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE always falls back to IDLE unless a new request arrives
        state_d = ST_IDLE;
        if (bus.start) begin
          r_d     = bus.D;
          fill_d  = bus.arith & bus.D[WIDTH-1];
          cnt_d   = w_amt;
          state_d = (w_amt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        r_d   = {fill_q, r_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  // Outputs come straight from registers, no path from inputs
  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_DONE);
  assign bus.R    = r_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_right_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_right_seq
// Description : Self-checking bench for shift_right_seq: directed corner
//               cases, back-to-back requests, mid-operation reset and
//               randomized operations against a shift reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_right_seq;
  import shift_right_seq_pkg::*;

  localparam int W = 8;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  shift_right_seq_if #(.WIDTH(W), .SHW(S)) bus ();

  shift_right_seq #(.WIDTH(W), .SHW(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: shift by the saturated amount using native shift operators
  function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input int b, input bit a);
    int n;
    logic signed [W-1:0] sd;
    n  = (b >= W) ? W : b;
    sd = d;
    if (a) return W'(sd >>> n);
    return W'(d >> n);
  endfunction

  // One request, then watch until done (bounded); checks latency, result,
  // busy duration, busy/done exclusivity and result hold afterwards
  task automatic do_op(input logic [W-1:0] d, input logic [S-1:0] b, input bit a,
                       input bit scramble, input string tag);
    int n, lat, nbusy;
    bit both;
    logic [W-1:0] exp;
    n   = (int'(b) >= W) ? W : int'(b);
    exp = ref_result(d, int'(b), a);
    @(negedge clk);
    bus.start = 1'b1;
    bus.D     = d;
    bus.B     = b;
    bus.arith = a;
    @(negedge clk);
    bus.start = 1'b0;
    lat   = 1;
    nbusy = 0;
    both  = 1'b0;
    while (!bus.done && lat < 40) begin
      if (bus.busy && bus.done) both = 1'b1;
      if (bus.busy) begin
        nbusy++;
        if (scramble) begin
          bus.D     = W'($urandom);
          bus.B     = S'($urandom);
          bus.arith = 1'($urandom);
          bus.start = 1'($urandom);
        end
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (bus.busy && bus.done) both = 1'b1;
    check({tag, ":latency"}, 32'(lat), 32'(n + 1));
    check({tag, ":R"}, 32'(bus.R), 32'(exp));
    check({tag, ":busy_cycles"}, 32'(nbusy), 32'(n));
    check({tag, ":busy_and_done"}, 32'(both), 32'd0);
    @(negedge clk);
    check({tag, ":done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, ":R_hold"}, 32'(bus.R), 32'(exp));
  endtask

  initial begin
    bit saw_done;

    // Reset with start asserted: request must be ignored
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.D     = 8'hAA;
    bus.B     = 4'd3;
    bus.arith = 1'b1;
    repeat (2) @(negedge clk);
    check("reset:R", 32'(bus.R), 32'd0);
    check("reset:busy", 32'(bus.busy), 32'd0);
    check("reset:done", 32'(bus.done), 32'd0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("post_reset:busy", 32'(bus.busy), 32'd0);
    check("post_reset:done", 32'(bus.done), 32'd0);

    // Directed corner cases
    do_op(8'hB4, 4'd2,  1'b0, 1'b0, "b4_lsr2");
    do_op(8'hB4, 4'd2,  1'b1, 1'b0, "b4_asr2");
    do_op(8'h80, 4'd15, 1'b1, 1'b0, "80_asr15");
    do_op(8'h80, 4'd15, 1'b0, 1'b0, "80_lsr15");
    do_op(8'h5A, 4'd0,  1'b0, 1'b0, "5a_b0");
    do_op(8'hC3, 4'd8,  1'b1, 1'b0, "c3_asr8");
    do_op(8'hC3, 4'd7,  1'b0, 1'b1, "c3_lsr7");

    // start held high: a done every second cycle, inputs churned mid-shift
    @(negedge clk);
    bus.start = 1'b1;
    bus.D     = 8'h0F;
    bus.B     = 4'd1;
    bus.arith = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      check("b2b:done", 32'(bus.done), 32'((j % 2) == 0));
      check("b2b:busy", 32'(bus.busy), 32'((j % 2) == 1));
      if (bus.done) begin
        check("b2b:R", 32'(bus.R), 32'h07);
      end
      if (bus.busy) begin
        bus.D     = W'($urandom);
        bus.B     = S'($urandom);
        bus.arith = 1'($urandom);
      end else begin
        bus.D     = 8'h0F;
        bus.B     = 4'd1;
        bus.arith = 1'b0;
      end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a long operation aborts it silently
    @(negedge clk);
    bus.start = 1'b1;
    bus.D     = W'($urandom);
    bus.B     = 4'd6;
    bus.arith = 1'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst:busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst:busy", 32'(bus.busy), 32'd0);
    check("midrst:done", 32'(bus.done), 32'd0);
    check("midrst:R", 32'(bus.R), 32'd0);
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_done = saw_done | bus.done;
    end
    check("midrst:no_done", 32'(saw_done), 32'd0);
    do_op(8'hF0, 4'd4, 1'b0, 1'b0, "after_rst");

    // Randomized operations with input churn while shifting
    repeat (40) begin
      do_op(W'($urandom), S'($urandom), 1'($urandom), 1'b1, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data and result width in bits.
REQ-002 The block SHALL have parameter SHW, default 4, shift-amount width in bits.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  request; sampled only when the block is accepting (IDLE or DONE).
REQ-007 D  input  WIDTH  operand to shift right.
REQ-008 B  input  SHW  shift amount, unsigned.
REQ-009 arith  input  1  1 = arithmetic (sign-fill from D[WIDTH-1]), 0 = logical (zero-fill).
REQ-010 busy  output  1  high while an operation is in progress (SHIFT state).
REQ-011 done  output  1  single-cycle pulse; R is valid from this cycle.
REQ-012 R  output  WIDTH  result register.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-014 In IDLE or DONE with start=1, the block SHALL latch D into R, arith into a fill bit, and min(B, WIDTH) into a count register.
- Next state SHALL be SHIFT if the latched count is nonzero, otherwise DONE.
REQ-015 In SHIFT, each clock SHALL shift R right by exactly one bit, insert the fill bit at the MSB, and decrement the count.
- On the edge where the count goes from 1 to 0, the next state SHALL be DONE.
REQ-016 Latency: done SHALL be high in the cycle min(B, WIDTH)+1 after the cycle in which start was sampled.
- Example: B=0 gives 1 cycle; B=3 gives 4 cycles; B=15 gives 9 cycles.
REQ-017 Shift amounts >= WIDTH SHALL yield all-zero (logical) or all-sign (arithmetic) results.
REQ-018 DONE SHALL last exactly one cycle.
- Without start, the next state SHALL be IDLE.
- With start, a new operation SHALL be accepted back-to-back, with no idle cycle.
REQ-019 start SHALL be ignored while in SHIFT; D, B and arith SHALL NOT affect an operation in progress.
REQ-020 busy SHALL be high in SHIFT only; done SHALL be high in DONE only; they SHALL never both be high.
REQ-021 R SHALL hold its final value from DONE until the next accepted start.
- Intermediate values SHALL be visible on R during SHIFT and are not guaranteed meaningful.
REQ-022 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs.

Reset
REQ-023 With rst_n=0 at a rising edge, the next state SHALL be IDLE, with R=0, count=0, fill=0, busy=0 and done=0.
REQ-024 Reset asserted during SHIFT or DONE SHALL abort the operation with no done pulse.
- The first start sampled after rst_n returns high SHALL be accepted normally.
REQ-025 start sampled in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-026 A shared package SHALL hold the state encoding type (IDLE, SHIFT, DONE) and the default WIDTH/SHW constants, for reuse by the left-shift path and future ALU shifters.
REQ-027 No sub-module is required; the count/shift datapath and the FSM SHALL reside in shift_right_seq.

Verification
REQ-028 D=8'hB4, B=2, arith=0, start pulse -> done 3 cycles later, R=8'h2D; busy high for exactly 2 cycles.
REQ-029 D=8'hB4, B=2, arith=1 -> R=8'hED at done.
- D=8'h80, B=15, arith=1 -> R=8'hFF with done 9 cycles after start.
- D=8'h80, B=15, arith=0 -> R=8'h00 with done 9 cycles after start.
REQ-030 D=8'h5A, B=0 -> done in the next cycle, R=8'h5A, busy never high.
REQ-031 start held high continuously with D=8'h0F, B=1 -> a done pulse every 2 cycles with R=8'h07.
- Changing D and B during SHIFT -> result unchanged.
REQ-032 rst_n=0 for 1 cycle in the middle of a B=6 operation -> no done, R=0, state IDLE.
- A following start with D=8'hF0, B=4, arith=0 -> R=8'h0F, done 5 cycles after start.
